// File: rtl/sw_debounce.sv
// sw_debounce: synchronise, debounce and edge-detect a raw switch bus with a sticky change flag.
module sw_debounce #(
  parameter int WIDTH        = 16,
  parameter int DIV          = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_sw,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_sw,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_changed,
  output logic             o_tick
);
  localparam int PW = $clog2(DIV);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);
  logic [WIDTH-1:0] s1_q, s2_q, sw_q, sw_d, rise_q, rise_d, fall_q, fall_d, acc;
  logic [PW-1:0]    pre_q, pre_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic             changed_q, changed_d, tick;
  assign tick = pre_q == PRE_MAX;
  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
    acc   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      acc[i]   = (s2_q[i] != sw_q[i]) && tick && (cnt_q[i] == CNT_MAX);
      // any cycle back at the accepted level restarts the count
      cnt_d[i] = (s2_q[i] == sw_q[i] || acc[i]) ? '0 : tick ? cnt_q[i] + 1'b1 : cnt_q[i];
    end
    sw_d      = sw_q ^ acc;
    rise_d    = acc & s2_q;
    fall_d    = acc & ~s2_q;
    changed_d = (|acc) | (changed_q & ~i_clear);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      sw_q      <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      pre_q     <= '0;
      changed_q <= 1'b0;
      cnt_q     <= '{default: '0};
    end else begin
      s1_q      <= i_sw;
      s2_q      <= s1_q;
      sw_q      <= sw_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pre_q     <= pre_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end
  assign o_sw      = sw_q;
  assign o_rise    = rise_q;
  assign o_fall    = fall_q;
  assign o_changed = changed_q;
  assign o_tick    = tick;
endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input conditioner for the board slide switches. It synchronises, debounces and edge-detects the raw switch bus before it reaches the processor's memory-mapped switch port (read at 0x8008). It runs on the board master clock, upstream of the clock divider. It presents the following to the top level:
- a stable switch vector;
- per-bit rise and fall strobes;
- a sticky "something changed" flag that software-visible logic can poll and clear.

## Interface
Parameters:
- WIDTH, 16, number of switch bits.
- DIV, 50000, prescaler period in clk cycles between sample ticks; legal range ≥ 2.
- STABLE_TICKS, 10, consecutive differing ticks required to accept a new level; legal range 1..255.

Ports:
- clk  input  1  board master clock; single clock domain for the whole block.
- reset  input  1  asynchronous, active-high reset.
- i_sw  input  WIDTH  raw, asynchronous switch levels.
- i_clear  input  1  synchronous clear of o_changed.
- o_sw  output  WIDTH  debounced switch levels.
- o_rise  output  WIDTH  one-cycle strobe per bit on an accepted 0→1 change.
- o_fall  output  WIDTH  one-cycle strobe per bit on an accepted 1→0 change.
- o_changed  output  1  sticky flag, set on any accepted change.
- o_tick  output  1  prescaler tick, for observation and test.

## Operation
- **Synchroniser:** two flops per bit (s1, s2). s2 is the synchronised level.
- **Prescaler:**
  - Counter runs 0..DIV-1 and wraps to 0.
  - o_tick = 1 exactly in the cycle the counter equals DIV-1. Combinational from the counter; no extra register.
- **Per-bit debounce counter** cnt[i], width clog2(STABLE_TICKS+1). Evaluated every cycle in priority order:
  1. If s2[i] == o_sw[i]: cnt[i] ← 0, regardless of tick.
  2. Else if tick and cnt[i] == STABLE_TICKS-1: o_sw[i] ← s2[i], cnt[i] ← 0. This is the accepted change.
  3. Else if tick: cnt[i] ← cnt[i]+1.
  4. Else: hold.
- **Glitch rejection:** any single cycle in which s2 returns to o_sw restarts the count. A bounce shorter than one tick period can therefore still reset progress.
- **Strobes:** o_rise[i] / o_fall[i] are registered and asserted for exactly the cycle in which o_sw[i] already shows the new value. They are 0 in all other cycles. Multiple bits may strobe in the same cycle.
- **Sticky flag o_changed:**
  - Set on the edge where any bit accepts a change.
  - Cleared on the edge where i_clear = 1.
  - If set and clear occur on the same edge, set wins and o_changed stays 1.
- **Bits are independent.** No bit's counter is affected by another bit's activity.

## Timing
- Reset values: s1, s2, o_sw, all cnt, the prescaler, o_rise, o_fall and o_changed are all 0. o_tick = 0 while reset is held.
- Reset is asynchronous: asserting it mid-count discards all progress immediately. Deassertion restarts the prescaler from 0.
- Switches already high at reset release produce the normal rise strobes and set o_changed once debounced. This is intended.
- Latency, measured from an i_sw edge captured at clock edge 0 (s2 updates at edge 2) to the edge where o_sw updates:
  - minimum 2 + (STABLE_TICKS-1)·DIV + 1 cycles;
  - maximum 2 + STABLE_TICKS·DIV cycles.
- Strobe and o_sw update occur on the same edge, with zero added latency.
- o_changed updates on the same edge as the strobe.
- i_clear takes effect on the next edge and has no latency beyond that.
- Outputs are quasi-static. The divided processor clock samples o_sw directly, and no handshake is required.

## Test plan
Run with DIV=4, STABLE_TICKS=3.
- **Reset:** hold reset with i_sw=16'hFFFF. Required: all outputs are 0. Release reset. Required: o_sw becomes 16'hFFFF within 14 cycles, o_rise=16'hFFFF for exactly 1 cycle, and o_changed=1.
- **Clean step:** from o_sw=0, set i_sw[3]=1 and hold it. Required: o_sw[3] rises 11–14 cycles later, o_rise=16'h0008 for 1 cycle, o_fall=0 throughout.
- **Bounce:** from o_sw=0, toggle i_sw[0] 1,0,1 with 5-cycle phases, then hold 1. Required: no o_sw change during the bounce; o_sw[0] rises 11–14 cycles after the final 0→1; exactly one o_rise[0] pulse.
- **Glitch rejection:** a 1-cycle high pulse on i_sw[7] at any phase. Required: o_sw, o_rise and o_changed stay 0 for at least 20 cycles.
- **Sticky flag collision:** with o_changed=1, drive i_clear=1 on the same edge that i_sw[5] (previously 1) is accepted as 0. Required: o_changed stays 1 and o_fall[5] pulses. i_clear=1 on the next edge with no change pending. Required: o_changed=0.
- **Async reset mid-count:** make i_sw[2] differ for 9 cycles, then assert reset for 1 cycle between clock edges. Required: outputs are 0 immediately, and after release a full 11–14 cycle window is required again before o_sw[2] changes.
